// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: 2x2 round-robin crossbar arbiter; in m*_req/m*_tgt, s*_done; out m*_gnt, sel (1 = swapped), s*_busy
module crossbar_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m0_tgt,
  input  logic m1_req,
  input  logic m1_tgt,
  input  logic s0_done,
  input  logic s1_done,
  output logic m0_gnt,
  output logic m1_gnt,
  output logic sel,
  output logic s0_busy,
  output logic s1_busy
);
  logic rr, d0, d1, g0, g1, n0, n1, nsel, nrr;
  always_comb begin
    d0 = sel ? s1_done : s0_done;
    d1 = sel ? s0_done : s1_done;
    g0 = m0_gnt & m0_req & ~d0;
    g1 = m1_gnt & m1_req & ~d1;
    n0 = g0;
    n1 = g1;
    nsel = sel;
    nrr = rr;
    if (g0 && !g1) n1 = m1_req && (m1_tgt != m0_tgt);
    else if (g1 && !g0) n0 = m0_req && (m0_tgt != m1_tgt);
    else if (!g0 && !g1) begin
      if (m0_req && m1_req && (m0_tgt != m1_tgt)) begin
        n0 = 1'b1;
        n1 = 1'b1;
        nsel = m0_tgt;
      end else if (m0_req && m1_req) begin
        n0 = ~rr;
        n1 = rr;
        nsel = rr ? ~m1_tgt : m0_tgt;
        nrr = ~rr;
      end else if (m0_req) begin
        n0 = 1'b1;
        nsel = m0_tgt;
      end else if (m1_req) begin
        n1 = 1'b1;
        nsel = ~m1_tgt;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      sel <= 1'b0;
      rr <= 1'b0;
      s0_busy <= 1'b0;
      s1_busy <= 1'b0;
    end else begin
      m0_gnt <= n0;
      m1_gnt <= n1;
      sel <= nsel;
      rr <= nrr;
      s0_busy <= (n0 & ~nsel) | (n1 & nsel);
      s1_busy <= (n0 & nsel) | (n1 & ~nsel);
    end
endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed scoreboard bench for crossbar_arbiter
module tb_crossbar_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 1'b0, m0_tgt = 1'b0, m1_req = 1'b0, m1_tgt = 1'b0, s0_done = 1'b0, s1_done = 1'b0;
  logic m0_gnt, m1_gnt, sel, s0_busy, s1_busy;
  logic [4:0] obs;
  typedef struct {
    string tag;
    logic [4:0] v;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  crossbar_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_tgt(m0_tgt), .m1_req(m1_req), .m1_tgt(m1_tgt),
    .s0_done(s0_done), .s1_done(s1_done),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .sel(sel), .s0_busy(s0_busy), .s1_busy(s1_busy)
  );
  always #5 clk = ~clk;
  assign obs = {m0_gnt, m1_gnt, sel, s0_busy, s1_busy};
  task automatic check();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed %b expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s observed gnt01/sel/busy01=%b expected %b", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic cyc(input string tag, input logic [5:0] in, input logic [4:0] v);
    {m0_req, m0_tgt, m1_req, m1_tgt, s0_done, s1_done} = in;
    sb.push_back('{tag, v});
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    #2;
    sb.push_back('{"reset_state", 5'b00000});
    check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("r35_grant",      6'b110000, 5'b10101);
    cyc("r35_hold1",      6'b110000, 5'b10101);
    cyc("r35_hold2",      6'b110000, 5'b10101);
    cyc("r35_release",    6'b000001, 5'b00100);
    cyc("r28_sel_hold",   6'b000000, 5'b00100);
    cyc("r36_both",       6'b111000, 5'b11111);
    cyc("r36_drop",       6'b000000, 5'b00100);
    cyc("r37_tie_m0",     6'b101000, 5'b10010);
    cyc("r37_m1_waits",   6'b101000, 5'b10010);
    cyc("r37_m1_after",   6'b001010, 5'b01110);
    cyc("r37_m1_release", 6'b000010, 5'b00100);
    cyc("r37_tie_m1",     6'b101000, 5'b01110);
    cyc("r37_idle",       6'b000000, 5'b00100);
    cyc("r23_tie_m0",     6'b101000, 5'b10010);
    cyc("r23_idle",       6'b000000, 5'b00000);
    cyc("r38_m0_s0",      6'b100000, 5'b10010);
    cyc("r38_m1_free",    6'b101100, 5'b11011);
    cyc("r38_dual_done",  6'b000011, 5'b00000);
    cyc("r20_own",        6'b100000, 5'b10010);
    cyc("r26_wait",       6'b101000, 5'b10010);
    cyc("r20_handover",   6'b101010, 5'b01110);
    cyc("r20_idle",       6'b000000, 5'b00100);
    cyc("r40_grant",      6'b110000, 5'b10101);
    cyc("r40_abort",      6'b000000, 5'b00100);
    cyc("r40_stray_done", 6'b000001, 5'b00100);
    cyc("r39_grant",      6'b001100, 5'b01001);
    #3 rst_n = 1'b0;
    #1 sb.push_back('{"r39_async_reset", 5'b00000});
    check();
    cyc("r33_done_in_rst", 6'b000001, 5'b00000);
    rst_n = 1'b1;
    cyc("r39_done_after",  6'b000001, 5'b00000);
    cyc("r34_first_arb",   6'b100000, 5'b10010);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
